vx_warp_ibuffer: RTL and testbench
==================================

# vx_warp_ibuffer

Per-issue-slot instruction buffer between decode and the scoreboard. Holds decoded instructions in one FIFO per warp of the slot and presents one instruction per cycle to the scoreboard. The warp is chosen by a round-robin policy that is locked while the scoreboard back-pressures. One instance per issue slot (`ISSUE_WIDTH` instances); its output feeds the scoreboard's `ibuffer_if` slave.

## Interface
- `NUM_WARPS`, default 4: warps mapped to this slot (`ISSUE_RATIO`); ≥1.
- `DEPTH`, default 2: entries per warp queue; power of two, ≥2.
- `DATAW`, default 64: decoded-instruction payload width, excluding `wis`.
- `WIS_W`, derived: `CLOG2(NUM_WARPS)`, minimum 1.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `dec_valid` in 1: decode instruction valid.
- `dec_wis` in `WIS_W`: warp-in-slot of the decode instruction.
- `dec_data` in `DATAW`: decode payload.
- `dec_ready` out 1: accept; equals `count[dec_wis] < DEPTH`.
- `ibuf_valid` out 1: instruction presented to the scoreboard.
- `ibuf_wis` out `WIS_W`: warp of the presented instruction.
- `ibuf_data` out `DATAW`: head entry of the granted warp queue.
- `ibuf_ready` in 1: scoreboard accept.
- `warp_empty` out `NUM_WARPS`: per-warp queue-empty flags, for the warp scheduler.
- `warp_full` out `NUM_WARPS`: per-warp queue-full flags, for fetch throttling.

## Operation
- Per-warp state: circular storage `[DEPTH][DATAW]`, `wr_ptr` and `rd_ptr` of `CLOG2(DEPTH)` bits (natural wrap), `count` of `CLOG2(DEPTH+1)` bits.
- Enqueue fires on `dec_valid && dec_ready`. It writes `storage[dec_wis][wr_ptr]`, increments `wr_ptr`, and increments `count`.
- Dequeue fires on `ibuf_valid && ibuf_ready`. It increments `rd_ptr` of `ibuf_wis` and decrements its `count`.
- Enqueue and dequeue on the same warp in the same cycle: both happen and `count` is unchanged. This is legal only when the queue is not full, because `dec_ready` uses the pre-dequeue count. A full queue never passes an instruction through in the same cycle.
- No same-cycle bypass: an enqueued entry is visible at the head no earlier than the next cycle.
- Grant:
  - `ibuf_valid = |~warp_empty`.
  - When not locked, grant the first non-empty warp searching upward from `(last_grant+1) mod NUM_WARPS`, with wrap.
  - `last_grant` updates to the granted warp on each dequeue only.
- Lock: if `ibuf_valid && !ibuf_ready` at a clock edge, the next cycle's grant is forced to the same warp. `ibuf_wis` and `ibuf_data` are held stable until that instruction fires, regardless of enqueues to other warps.
- Lock clears on the firing cycle.
- `NUM_WARPS==1`: grant is constant 0 and `ibuf_wis` is tied to 0.

## Timing
- Reset values:
  - all `count`, `wr_ptr` and `rd_ptr` = 0.
  - `last_grant = NUM_WARPS-1`, so warp 0 wins first.
  - lock = 0.
  - `ibuf_valid = 0`, `warp_empty` all 1, `warp_full` all 0.
  - `ibuf_data` is don't-care.
- Reset mid-operation discards all queued entries; no dequeue is reported in the reset cycle.
- Enqueue-to-`ibuf_valid` latency: 1 cycle when the queue was empty and the warp is granted.
- Throughput: 1 instruction per cycle sustained. Round-robin alternates warps cycle by cycle when several are non-empty.
- `dec_ready` and `ibuf_valid` are combinational from registered state only:
  - `dec_ready` does not depend on `ibuf_ready`.
  - `ibuf_valid` does not depend on `dec_valid`.
- `warp_empty` and `warp_full` are registered-state decodes of `count`.
- Handshake rule: once `ibuf_valid` is asserted it stays asserted, with `ibuf_wis` and `ibuf_data` unchanged, until `ibuf_ready`.

## Structure
- `VX_gpu_pkg` holds the `ISSUE_WIS_W` derivation and the `IBUF_DEPTH` default constant.
- One sub-module, `vx_warp_queue`: a single-warp circular FIFO with ports `push`, `pop`, `data_in`, `data_out` (head), `empty`, `full`. Instantiate `NUM_WARPS` copies.
- Round-robin grant with lock stays in the top module.

## Test plan
- **Reset then idle.** Expect `ibuf_valid=0`, `warp_empty=4'b1111`, `dec_ready=1` for all `wis`.
- **Fill and overflow.** Enqueue 3 instructions to warp 2 with `DEPTH=2` and `ibuf_ready=0`.
  - Expect the first 2 accepted, `warp_full[2]=1`, and `dec_ready=0` on the third.
  - Expect the third accepted the cycle after `ibuf_ready` fires warp 2.
- **Round-robin.** Preload warps 0, 1 and 3 with 2 entries each, then hold `ibuf_ready=1`.
  - Expect `ibuf_wis` sequence 0,1,3,0,1,3, then `ibuf_valid=0`.
- **Lock under stall.** Warps 0 and 1 non-empty, warp 0 granted, `ibuf_ready=0` for 5 cycles while warp 2 is enqueued.
  - Expect `ibuf_wis=0` and `ibuf_data` constant throughout.
  - After the fire, expect the next grant to be warp 1.
- **Simultaneous push/pop.** Warp 1 holding 1 entry, enqueue and dequeue warp 1 in the same cycle.
  - Expect `count` unchanged and the new entry presented next cycle in FIFO order.
- **Reset mid-stream.** Assert `reset` with 4 entries queued.
  - Next cycle expect `ibuf_valid=0` and all `warp_empty=1`.
  - Expect the first post-reset grant to be the lowest non-empty warp.

Source files
------------

// File: rtl/vx_warp_ibuffer_pkg.sv
// ---------------------------------------------------------------------------
// vx_warp_ibuffer_pkg
// Shared constants and helpers for the per-issue-slot instruction buffer.
//   IBUF_DEPTH     : default number of entries per warp queue
//   issue_wis_w()  : width of a warp-in-slot index, never less than 1 bit
//   grant_mode_e   : round-robin arbiter mode (free-running or locked)
// ---------------------------------------------------------------------------
package vx_warp_ibuffer_pkg;

  localparam int IBUF_DEPTH = 2;

  // A slot with a single warp still carries a 1-bit index so ports never
  // collapse to zero width.
  function automatic int issue_wis_w(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  typedef enum logic {
    GM_FREE   = 1'b0,
    GM_LOCKED = 1'b1
  } grant_mode_e;

endpackage

// File: rtl/vx_warp_ibuffer_queue.sv
// ---------------------------------------------------------------------------
// vx_warp_queue
// Single-warp circular FIFO used by vx_warp_ibuffer.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_push         : write i_data_in at the tail (caller guarantees !o_full)
//   i_pop          : retire the head entry (caller guarantees !o_empty)
//   i_data_in      : payload to enqueue
//   o_data_out     : current head entry (valid when !o_empty)
//   o_empty/o_full : decodes of the registered occupancy count
// Push and pop in the same cycle leave the count unchanged. There is no
// bypass: a pushed entry reaches the head no earlier than the next cycle.
// ---------------------------------------------------------------------------
module vx_warp_queue #(
  parameter int DEPTH = 2,
  parameter int DATAW = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [DATAW-1:0] i_data_in,
  output logic [DATAW-1:0] o_data_out,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATAW-1:0] r_storage [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; the head is only consumed when valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_storage[r_wr_ptr] <= i_data_in;
  end

  assign o_data_out = r_storage[r_rd_ptr];
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/vx_warp_ibuffer.sv
// ---------------------------------------------------------------------------
// vx_warp_ibuffer
// Per-issue-slot instruction buffer: one FIFO per warp, one instruction per
// cycle presented to the scoreboard under a lockable round-robin grant.
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_dec_valid        : decode instruction valid
//   i_dec_wis          : warp-in-slot of the decode instruction
//   i_dec_data         : decode payload
//   o_dec_ready        : target warp queue has room (pre-dequeue occupancy)
//   o_ibuf_valid       : some warp queue is non-empty
//   o_ibuf_wis         : granted warp
//   o_ibuf_data        : head entry of the granted warp
//   i_ibuf_ready       : scoreboard accept
//   o_warp_empty/full  : per-warp occupancy flags
//
// Grant mode FSM
//   state     | meaning
//   GM_FREE   | grant follows round-robin from r_last_grant+1
//   GM_LOCKED | presented instruction stalled; grant pinned to r_lock_wis
// ---------------------------------------------------------------------------
module vx_warp_ibuffer
  import vx_warp_ibuffer_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = IBUF_DEPTH,
  parameter int DATAW     = 64,
  parameter int WIS_W     = issue_wis_w(NUM_WARPS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_dec_valid,
  input  logic [WIS_W-1:0]     i_dec_wis,
  input  logic [DATAW-1:0]     i_dec_data,
  output logic                 o_dec_ready,
  output logic                 o_ibuf_valid,
  output logic [WIS_W-1:0]     o_ibuf_wis,
  output logic [DATAW-1:0]     o_ibuf_data,
  input  logic                 i_ibuf_ready,
  output logic [NUM_WARPS-1:0] o_warp_empty,
  output logic [NUM_WARPS-1:0] o_warp_full
);

  logic [NUM_WARPS-1:0] w_push;
  logic [NUM_WARPS-1:0] w_pop;
  logic [NUM_WARPS-1:0] w_empty;
  logic [NUM_WARPS-1:0] w_full;
  logic [DATAW-1:0]     w_head [NUM_WARPS];

  logic                 w_dec_ready;
  logic                 w_valid;
  logic                 w_fire;
  logic [WIS_W-1:0]     w_rr_grant;
  logic [WIS_W-1:0]     w_grant;
  int                   w_dist;
  int                   w_best;

  grant_mode_e          r_mode;
  logic [WIS_W-1:0]     r_lock_wis;
  logic [WIS_W-1:0]     r_last_grant;

  // -------------------------------------------------------------------------
  // Per-warp queues
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_queue
    vx_warp_queue #(
      .DEPTH (DEPTH),
      .DATAW (DATAW)
    ) u_queue (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_push     (w_push[gi]),
      .i_pop      (w_pop[gi]),
      .i_data_in  (i_dec_data),
      .o_data_out (w_head[gi]),
      .o_empty    (w_empty[gi]),
      .o_full     (w_full[gi])
    );
  end

  // -------------------------------------------------------------------------
  // Decode side: ready depends only on registered occupancy, never on the
  // scoreboard, so a full queue cannot pass an instruction through.
  // -------------------------------------------------------------------------
  always_comb begin
    w_dec_ready = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (i_dec_wis == WIS_W'(i)) w_dec_ready = ~w_full[i];
    end
  end

  always_comb begin
    w_push = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_push[i] = i_dec_valid && w_dec_ready && (i_dec_wis == WIS_W'(i));
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin search: pick the non-empty warp at the smallest distance
  // past r_last_grant, wrapping modulo NUM_WARPS (need not be a power of 2).
  // -------------------------------------------------------------------------
  always_comb begin
    w_rr_grant = '0;
    w_best     = NUM_WARPS;
    w_dist     = 0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_dist = (i + NUM_WARPS - 1 - int'(r_last_grant)) % NUM_WARPS;
      if (!w_empty[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_rr_grant = WIS_W'(i);
      end
    end
  end

  assign w_valid = |(~w_empty);
  assign w_grant = (NUM_WARPS == 1)     ? '0         :
                   (r_mode == GM_LOCKED) ? r_lock_wis : w_rr_grant;
  assign w_fire  = w_valid && i_ibuf_ready;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_pop[i] = w_fire && (w_grant == WIS_W'(i));
    end
  end

  always_comb begin
    o_ibuf_data = w_head[0];
    for (int i = 1; i < NUM_WARPS; i++) begin
      if (w_grant == WIS_W'(i)) o_ibuf_data = w_head[i];
    end
  end

  // -------------------------------------------------------------------------
  // Grant mode FSM. r_last_grant starts at the top warp so warp 0 wins
  // first, and only moves on an actual dequeue.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mode       <= GM_FREE;
      r_lock_wis   <= '0;
      r_last_grant <= WIS_W'(NUM_WARPS - 1);
    end else begin
      if (w_fire) r_last_grant <= w_grant;
      case (r_mode)
        GM_FREE: begin
          if (w_valid && !i_ibuf_ready) begin
            r_mode     <= GM_LOCKED;
            r_lock_wis <= w_grant;
          end
        end
        GM_LOCKED: begin
          if (w_fire) r_mode <= GM_FREE;
        end
        default: r_mode <= GM_FREE;
      endcase
    end
  end

  assign o_dec_ready  = w_dec_ready;
  assign o_ibuf_valid = w_valid;
  assign o_ibuf_wis   = w_grant;
  assign o_warp_empty = w_empty;
  assign o_warp_full  = w_full;

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
module tb_vx_warp_ibuffer;

  localparam int NW = 4;
  localparam int DP = 2;
  localparam int DW = 64;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          dec_valid;
  logic [WW-1:0] dec_wis;
  logic [DW-1:0] dec_data;
  logic          dec_ready;
  logic          ibuf_valid;
  logic [WW-1:0] ibuf_wis;
  logic [DW-1:0] ibuf_data;
  logic          ibuf_ready;
  logic [NW-1:0] warp_empty;
  logic [NW-1:0] warp_full;

  always #5 clk = ~clk;

  vx_warp_ibuffer #(
    .NUM_WARPS (NW),
    .DEPTH     (DP),
    .DATAW     (DW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_dec_valid  (dec_valid),
    .i_dec_wis    (dec_wis),
    .i_dec_data   (dec_data),
    .o_dec_ready  (dec_ready),
    .o_ibuf_valid (ibuf_valid),
    .o_ibuf_wis   (ibuf_wis),
    .o_ibuf_data  (ibuf_data),
    .i_ibuf_ready (ibuf_ready),
    .o_warp_empty (warp_empty),
    .o_warp_full  (warp_full)
  );

  // Reference model: plain queues per warp plus round-robin bookkeeping.
  logic [DW-1:0] mq [NW][$];
  int            m_last;
  bit            m_locked;
  int            m_lock_wis;

  int n_pass   = 0;
  int n_checks = 0;

  function automatic bit m_valid();
    for (int w = 0; w < NW; w++) if (mq[w].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_grant();
    if (m_locked) return m_lock_wis;
    for (int k = 1; k <= NW; k++) begin
      if (mq[(m_last + k) % NW].size() > 0) return (m_last + k) % NW;
    end
    return 0;
  endfunction

  task automatic m_reset();
    for (int w = 0; w < NW; w++) mq[w].delete();
    m_last     = NW - 1;
    m_locked   = 1'b0;
    m_lock_wis = 0;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called with clk low and inputs already driven; checks outputs, advances
  // one clock, updates the model and returns at the following negedge.
  task automatic cycle();
    logic [NW-1:0] e_empty;
    logic [NW-1:0] e_full;
    int g;
    bit v, rdy, fire, push;
    #1;
    for (int w = 0; w < NW; w++) begin
      e_empty[w] = (mq[w].size() == 0);
      e_full[w]  = (mq[w].size() == DP);
    end
    v   = m_valid();
    g   = m_grant();
    rdy = (mq[dec_wis].size() < DP);
    chk("dec_ready", {63'd0, dec_ready}, {63'd0, rdy});
    chk("ibuf_valid", {63'd0, ibuf_valid}, {63'd0, v});
    chk("warp_empty", {60'd0, warp_empty}, {60'd0, e_empty});
    chk("warp_full", {60'd0, warp_full}, {60'd0, e_full});
    if (v) begin
      chk("ibuf_wis", {62'd0, ibuf_wis}, DW'(g));
      chk("ibuf_data", ibuf_data, mq[g][0]);
    end
    push = dec_valid && rdy;
    fire = v && ibuf_ready;
    @(posedge clk);
    if (reset) begin
      m_reset();
    end else begin
      if (fire) begin
        void'(mq[g].pop_front());
        m_last   = g;
        m_locked = 1'b0;
      end else if (v) begin
        m_locked   = 1'b1;
        m_lock_wis = g;
      end
      if (push) mq[dec_wis].push_back(dec_data);
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int w, input logic [DW-1:0] d, input bit r);
    dec_valid  = v;
    dec_wis    = WW'(w);
    dec_data   = d;
    ibuf_ready = r;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held;
    logic [DW-1:0] d_new;
    int rr_exp [6];
    rr_exp = '{0, 1, 3, 0, 1, 3};

    reset = 1'b1;
    drive(0, 0, '0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();
    reset = 1'b0;

    // Reset then idle
    #1;
    chk("idle_valid", {63'd0, ibuf_valid}, 64'd0);
    chk("idle_empty", {60'd0, warp_empty}, 64'hF);
    for (int w = 0; w < NW; w++) begin
      dec_wis = WW'(w);
      #1;
      chk("idle_dec_ready", {63'd0, dec_ready}, 64'd1);
    end
    drive(0, 0, '0, 0);
    cycle();

    // Fill and overflow on warp 2
    drive(1, 2, rnd64(), 0); cycle();
    drive(1, 2, rnd64(), 0); cycle();
    chk("fill_full2", {63'd0, warp_full[2]}, 64'd1);
    drive(1, 2, rnd64(), 0);
    #1;
    chk("fill_third_refused", {63'd0, dec_ready}, 64'd0);
    cycle();
    ibuf_ready = 1'b1; cycle();
    ibuf_ready = 1'b0;
    #1;
    chk("fill_third_ready", {63'd0, dec_ready}, 64'd1);
    cycle();
    drive(0, 0, '0, 1);
    repeat (3) cycle();

    // Round-robin over warps 0,1,3
    reset = 1'b1; drive(0, 0, '0, 0); cycle(); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1, (k % 3 == 2) ? 3 : k % 3, rnd64(), 0);
      cycle();
    end
    drive(0, 0, '0, 1);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_seq", {62'd0, ibuf_wis}, DW'(rr_exp[k]));
      cycle();
    end
    chk("rr_drained", {63'd0, ibuf_valid}, 64'd0);

    // Lock under stall
    reset = 1'b1; drive(0, 0, '0, 0); cycle(); reset = 1'b0;
    drive(1, 0, rnd64(), 0); cycle();
    drive(1, 1, rnd64(), 0); cycle();
    held = ibuf_data;
    for (int k = 0; k < 5; k++) begin
      drive(1, 2, rnd64(), 0);
      #1;
      chk("lock_wis", {62'd0, ibuf_wis}, 64'd0);
      chk("lock_data", ibuf_data, held);
      cycle();
    end
    drive(0, 0, '0, 1); cycle();
    chk("lock_next_grant", {62'd0, ibuf_wis}, 64'd1);
    drive(0, 0, '0, 1);
    repeat (4) cycle();

    // Simultaneous push/pop on warp 1
    reset = 1'b1; drive(0, 0, '0, 0); cycle(); reset = 1'b0;
    drive(1, 1, rnd64(), 0); cycle();
    d_new = rnd64();
    drive(1, 1, d_new, 1); cycle();
    drive(0, 0, '0, 0);
    #1;
    chk("pp_not_empty", {63'd0, warp_empty[1]}, 64'd0);
    chk("pp_not_full", {63'd0, warp_full[1]}, 64'd0);
    chk("pp_new_head", ibuf_data, d_new);
    cycle();

    // Reset mid-stream with 4 entries queued
    drive(1, 3, rnd64(), 0); cycle();
    drive(1, 2, rnd64(), 0); cycle();
    drive(1, 2, rnd64(), 0); cycle();
    reset = 1'b1; drive(0, 0, '0, 1); cycle(); reset = 1'b0;
    drive(0, 0, '0, 0);
    #1;
    chk("rst_valid", {63'd0, ibuf_valid}, 64'd0);
    chk("rst_empty", {60'd0, warp_empty}, 64'hF);
    drive(1, 2, rnd64(), 0); cycle();
    drive(1, 3, rnd64(), 0);
    #1;
    chk("rst_first_grant", {62'd0, ibuf_wis}, 64'd2);
    cycle();
    drive(0, 0, '0, 1);
    repeat (4) cycle();

    // Randomised traffic against the model
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(199) == 0);
      drive($urandom_range(99) < 70, $urandom_range(NW - 1), rnd64(),
            $urandom_range(99) < 55);
      cycle();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
